rfphoenix_alu_sched: RTL and testbench

Round-robin scheduler that shares one combinational integer/compare ALU between NREQ thread issue ports of the rfPhoenix core. Accepts at most one operation per cycle, registers its operands into the ALU, and captures the ALU result into a tagged result register with valid/ready backpressure. It sits between the per-thread issue logic and the ALU, and feeds the writeback arbiter.

---
 rtl/rfphoenix_alu_sched.sv | 180 ++++++++++++++++++
 tb/tb_rfphoenix_alu_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_alu_sched.sv
// rfphoenix_alu_sched: round-robin issue scheduler in front of the shared
// integer/compare ALU. S1 registers the granted operands for the ALU and S2
// captures the tagged ALU result under valid/ready backpressure.
module rfphoenix_alu_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 5,
  parameter int unsigned IRW  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*IRW-1:0]      req_ir_i,
  input  logic [NREQ*32-1:0]       req_a_i,
  input  logic [NREQ*32-1:0]       req_b_i,
  input  logic [NREQ*32-1:0]       req_c_i,
  input  logic [NREQ*32-1:0]       req_imm_i,
  input  logic [NREQ*TAGW-1:0]     req_tag_i,
  output logic [IRW-1:0]           alu_ir_o,
  output logic [31:0]              alu_a_o,
  output logic [31:0]              alu_b_o,
  output logic [31:0]              alu_c_o,
  output logic [31:0]              alu_imm_o,
  input  logic [31:0]              alu_o_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_o,
  output logic [TAGW-1:0]          res_tag_o,
  output logic [$clog2(NREQ)-1:0]  res_src_o
);

  localparam int unsigned SRCW = $clog2(NREQ);

  // S1 operand register
  logic            s1_v_q,   s1_v_d;
  logic [IRW-1:0]  s1_ir_q,  s1_ir_d;
  logic [31:0]     s1_a_q,   s1_a_d;
  logic [31:0]     s1_b_q,   s1_b_d;
  logic [31:0]     s1_c_q,   s1_c_d;
  logic [31:0]     s1_imm_q, s1_imm_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [SRCW-1:0] s1_src_q, s1_src_d;

  // S2 result register
  logic            s2_v_q,   s2_v_d;
  logic [31:0]     s2_res_q, s2_res_d;
  logic [TAGW-1:0] s2_tag_q, s2_tag_d;
  logic [SRCW-1:0] s2_src_q, s2_src_d;

  logic [SRCW-1:0] rr_q, rr_d;

  logic            s2_free, s1_adv, s1_free, grant_en, grant;
  logic            gnt_found;
  logic [SRCW-1:0] gnt_idx;
  logic [SRCW:0]   cand_sum;
  logic [SRCW-1:0] cand_idx;

  assign s2_free  = !s2_v_q || res_ready_i;
  assign s1_adv   = s1_v_q && s2_free;
  assign s1_free  = !s1_v_q || s1_adv;
  // Reset gates the grant combinationally so ready drops with rst_ni, not at an edge.
  assign grant_en = rst_ni && s1_free && !flush_i;
  assign grant    = gnt_found && grant_en;

  // Round-robin search: first valid port at or after rr_q, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_q} + (SRCW+1)'(i);
      if (cand_sum >= (SRCW+1)'(NREQ)) cand_sum = cand_sum - (SRCW+1)'(NREQ);
      cand_idx = cand_sum[SRCW-1:0];
      if (!gnt_found && req_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // One-hot grant derived only from the search result, never from other readies.
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;
  end

  // Next-state for pointer and both pipeline stages.
  always_comb begin
    rr_d     = rr_q;
    s1_v_d   = s1_v_q;
    s1_ir_d  = s1_ir_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_c_d   = s1_c_q;
    s1_imm_d = s1_imm_q;
    s1_tag_d = s1_tag_q;
    s1_src_d = s1_src_q;
    s2_v_d   = s2_v_q;
    s2_res_d = s2_res_q;
    s2_tag_d = s2_tag_q;
    s2_src_d = s2_src_q;

    if (grant) begin
      rr_d = (gnt_idx == SRCW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    if (flush_i) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else begin
      if (grant) begin
        s1_v_d   = 1'b1;
        s1_ir_d  = req_ir_i [gnt_idx*IRW  +: IRW];
        s1_a_d   = req_a_i  [gnt_idx*32   +: 32];
        s1_b_d   = req_b_i  [gnt_idx*32   +: 32];
        s1_c_d   = req_c_i  [gnt_idx*32   +: 32];
        s1_imm_d = req_imm_i[gnt_idx*32   +: 32];
        s1_tag_d = req_tag_i[gnt_idx*TAGW +: TAGW];
        s1_src_d = gnt_idx;
      end else if (s1_adv) begin
        s1_v_d = 1'b0;
      end

      if (s1_adv) begin
        s2_v_d   = 1'b1;
        s2_res_d = alu_o_i;
        s2_tag_d = s1_tag_q;
        s2_src_d = s1_src_q;
      end else if (res_ready_i) begin
        s2_v_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight ops and clears all data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      s1_v_q   <= 1'b0;
      s1_ir_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_c_q   <= '0;
      s1_imm_q <= '0;
      s1_tag_q <= '0;
      s1_src_q <= '0;
      s2_v_q   <= 1'b0;
      s2_res_q <= '0;
      s2_tag_q <= '0;
      s2_src_q <= '0;
    end else begin
      rr_q     <= rr_d;
      s1_v_q   <= s1_v_d;
      s1_ir_q  <= s1_ir_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_c_q   <= s1_c_d;
      s1_imm_q <= s1_imm_d;
      s1_tag_q <= s1_tag_d;
      s1_src_q <= s1_src_d;
      s2_v_q   <= s2_v_d;
      s2_res_q <= s2_res_d;
      s2_tag_q <= s2_tag_d;
      s2_src_q <= s2_src_d;
    end
  end

  assign alu_ir_o    = s1_ir_q;
  assign alu_a_o     = s1_a_q;
  assign alu_b_o     = s1_b_q;
  assign alu_c_o     = s1_c_q;
  assign alu_imm_o   = s1_imm_q;
  assign res_valid_o = s2_v_q;
  assign res_o       = s2_res_q;
  assign res_tag_o   = s2_tag_q;
  assign res_src_o   = s2_src_q;

endmodule

// File: tb/tb_rfphoenix_alu_sched.sv
// Scoreboard bench for rfphoenix_alu_sched with a small stand-in ALU.
module tb_rfphoenix_alu_sched;
  localparam int NREQ = 4;
  localparam int TAGW = 5;
  localparam int IRW  = 32;

  localparam logic [IRW-1:0] OP_ADD  = 32'd1;
  localparam logic [IRW-1:0] OP_SUB  = 32'd2;
  localparam logic [IRW-1:0] OP_ADDI = 32'd3;
  localparam logic [IRW-1:0] OP_LTU  = 32'd4;
  localparam logic [IRW-1:0] OP_SRAI = 32'd5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*IRW-1:0]    req_ir = '0;
  logic [NREQ*32-1:0]     req_a = '0, req_b = '0, req_c = '0, req_imm = '0;
  logic [NREQ*TAGW-1:0]   req_tag = '0;
  logic [IRW-1:0]         alu_ir;
  logic [31:0]            alu_a, alu_b, alu_c, alu_imm, alu_o;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [31:0]            res;
  logic [TAGW-1:0]        res_tag;
  logic [1:0]             res_src;

  typedef struct packed {
    logic [31:0]     v;
    logic [TAGW-1:0] tag;
    logic [1:0]      src;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Port k in streaming tests: ADD a=k+1, b=0x10, tag=8+k.
  logic [31:0] stream_exp [4] = '{32'h11, 32'h12, 32'h13, 32'h14};

  rfphoenix_alu_sched #(.NREQ(NREQ), .TAGW(TAGW), .IRW(IRW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ir_i(req_ir), .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
    .req_imm_i(req_imm), .req_tag_i(req_tag),
    .alu_ir_o(alu_ir), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_o(alu_c),
    .alu_imm_o(alu_imm), .alu_o_i(alu_o),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_o(res), .res_tag_o(res_tag), .res_src_o(res_src)
  );

  always #5 clk = ~clk;

  // Stand-in combinational ALU
  always_comb begin
    case (alu_ir[3:0])
      4'd1:    alu_o = alu_a + alu_b;
      4'd2:    alu_o = alu_a - alu_b;
      4'd3:    alu_o = alu_a + alu_imm;
      4'd4:    alu_o = {31'b0, (alu_a < alu_b)};
      4'd5:    alu_o = $signed(alu_a) >>> alu_imm[4:0];
      default: alu_o = alu_c;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_port(input int k, input logic [IRW-1:0] ir, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [TAGW-1:0] tag);
    req_ir [k*IRW  +: IRW]  = ir;
    req_a  [k*32   +: 32]   = a;
    req_b  [k*32   +: 32]   = b;
    req_c  [k*32   +: 32]   = 32'h0;
    req_imm[k*32   +: 32]   = imm;
    req_tag[k*TAGW +: TAGW] = tag;
  endtask

  task automatic set_stream_ports();
    for (int k = 0; k < NREQ; k++) set_port(k, OP_ADD, 32'(k + 1), 32'h10, 32'h0, 5'(8 + k));
  endtask

  // Present one op on port k alone, wait (bounded) for its grant, then drop valid.
  task automatic issue_one(input int k, input logic [IRW-1:0] ir, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic [TAGW-1:0] tag,
                           input logic [31:0] exp_v, input bit push);
    set_port(k, ir, a, b, imm, tag);
    if (push) sb.push_back(exp_t'{v: exp_v, tag: tag, src: 2'(k)});
    req_valid = '0;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[k]) break;
    end
    chk("issue_grant", 32'(req_ready), 32'(1) << k);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got res=0x%08h tag=%0d src=%0d, none expected",
                   res, res_tag, res_src);
        end else begin
          e = sb.pop_front();
          if ({res, res_tag, res_src} !== e) begin
            n_fail++;
            $display("FAIL result: got res=0x%08h tag=%0d src=%0d expected res=0x%08h tag=%0d src=%0d",
                     res, res_tag, res_src, e.v, e.tag, e.src);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_o", res, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_res_src", 32'(res_src), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op latency: port 2 ADD 5+7, tag 3
    issue_one(2, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12, 1'b1);
    @(negedge clk);
    chk("lat_s2_empty", 32'(res_valid), 32'h0);
    chk("lat_alu_a", alu_a, 32'd5);
    chk("lat_alu_b", alu_b, 32'd7);
    chk("lat_alu_ir", alu_ir, OP_ADD);
    @(negedge clk);
    chk("lat_res_valid", 32'(res_valid), 32'h1);
    @(posedge clk); #1;
    idle(2);

    // Reset mid-flight: ADDI sits in S1 when reset drops between edges
    issue_one(0, OP_ADDI, 32'd10, 32'd0, 32'd5, 5'd9, 32'd15, 1'b0);
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_res_valid", 32'(res_valid), 32'h0);
    chk("midrst_s1_v", 32'(dut.s1_v_q), 32'h0);
    chk("midrst_alu_a", alu_a, 32'h0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst_no_result", 32'(res_valid), 32'h0);
    @(posedge clk); #1;

    // Round-robin: all ports valid for 8 grants, starting from pointer 0
    set_stream_ports();
    for (int i = 0; i < 8; i++)
      sb.push_back(exp_t'{v: stream_exp[i % 4], tag: 5'(8 + i % 4), src: 2'(i % 4)});
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1) << (i % 4));
      if (i >= 2) chk("rr_res_valid", 32'(res_valid), 32'h1);
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle(3);

    // Compare and shift ops on port 1
    issue_one(1, OP_SUB, 32'h0, 32'h1, 32'h0, 5'd4, 32'hFFFF_FFFF, 1'b1);
    idle(2);
    issue_one(1, OP_LTU, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd5, 32'h1, 1'b1);
    idle(2);
    issue_one(1, OP_SRAI, 32'h8000_0000, 32'h0, 32'd4, 5'd6, 32'hF800_0000, 1'b1);
    idle(2);

    // Backpressure: pointer is 2; p2 and p3 fill the pipe, then everything stalls
    set_stream_ports();
    sb.push_back(exp_t'{v: 32'h13, tag: 5'd10, src: 2'd2});
    sb.push_back(exp_t'{v: 32'h14, tag: 5'd11, src: 2'd3});
    sb.push_back(exp_t'{v: 32'h11, tag: 5'd8,  src: 2'd0});
    sb.push_back(exp_t'{v: 32'h12, tag: 5'd9,  src: 2'd1});
    sb.push_back(exp_t'{v: 32'h13, tag: 5'd10, src: 2'd2});
    sb.push_back(exp_t'{v: 32'h14, tag: 5'd11, src: 2'd3});
    res_ready = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("bp_grant_p2", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_grant_p3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      chk("bp_stall_alu_a", alu_a, 32'd4);
      chk("bp_stall_res", res, 32'h13);
      chk("bp_stall_valid", 32'(res_valid), 32'h1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("bp_resume_grant", 32'(req_ready), 32'(1) << j);
      @(posedge clk); #1;
    end
    req_valid = '0;
    idle(4);

    // Flush with S1 and S2 full; pointer 0 -> p0, p1 accepted and discarded
    res_ready = 1'b0;
    req_valid = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_full_valid", 32'(res_valid), 32'h1);
    chk("fl_ready_full", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_cleared", 32'(res_valid), 32'h0);
    chk("fl_no_grant", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    res_ready = 1'b1;
    sb.push_back(exp_t'{v: 32'h13, tag: 5'd10, src: 2'd2});
    @(negedge clk);
    chk("fl_next_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
